// File: rtl/fft_peak_detect.sv
// -----------------------------------------------------------------------------
// fft_peak_detect
//
// Frame analysis stage that sits after the 16-point FFT. A complete 16-bin
// frame is captured on a single-cycle fft_valid pulse. The bins are then
// scanned one per cycle, and the squared magnitude re*re + im*im of each is
// compared against a running maximum. When the scan ends, the index of the
// strongest bin is reported on freq together with a one-cycle done pulse.
//
// A new frame may be captured in the same cycle that the last bin of the
// current frame is scanned. As a result, frames spaced exactly 16 cycles apart
// are processed back-to-back with no idle cycle between them. A frame that
// arrives at any other point in a scan is dropped, and overrun is flagged.
//
// Ports
//   CLK        in   1   clock; all state updates on the rising edge
//   RST        in   1   asynchronous, active-high reset
//   fft_valid  in   1   single-cycle pulse qualifying fft_d0..fft_d15
//   fft_dK     in  32   bin K; [31:16] signed real, [15:0] signed imaginary
//   done       out  1   one-cycle pulse; freq is updated in the same cycle
//   freq       out  4   argmax bin of the last completed frame (held)
//   overrun    out  1   one-cycle pulse when a frame had to be dropped
// -----------------------------------------------------------------------------
module fft_peak_detect (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic        overrun
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Squared magnitude of one bin. Each 16x16 signed square is at most 2^30,
    // so the sum is at most 2^31. That value fits in an unsigned 32-bit word
    // without overflow.
    function automatic logic [31:0] mag_f(input logic [31:0] word);
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic signed [31:0] re_sq;
        logic signed [31:0] im_sq;
        re    = word[31:16];
        im    = word[15:0];
        re_sq = 32'(re) * 32'(re);
        im_sq = 32'(im) * 32'(im);
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] max_mag_q, max_mag_d;
    logic [3:0]  max_idx_q, max_idx_d;
    logic [31:0] buf_q [16];

    logic        done_q, done_d;
    logic [3:0]  freq_q, freq_d;
    logic        overrun_q, overrun_d;

    logic [31:0] in_words_s [16];
    logic        last_bin_s;
    logic        capture_s;
    logic [31:0] mag_s;
    logic [31:0] cand_mag_s;
    logic [3:0]  cand_idx_s;

    assign in_words_s[0]  = fft_d0;
    assign in_words_s[1]  = fft_d1;
    assign in_words_s[2]  = fft_d2;
    assign in_words_s[3]  = fft_d3;
    assign in_words_s[4]  = fft_d4;
    assign in_words_s[5]  = fft_d5;
    assign in_words_s[6]  = fft_d6;
    assign in_words_s[7]  = fft_d7;
    assign in_words_s[8]  = fft_d8;
    assign in_words_s[9]  = fft_d9;
    assign in_words_s[10] = fft_d10;
    assign in_words_s[11] = fft_d11;
    assign in_words_s[12] = fft_d12;
    assign in_words_s[13] = fft_d13;
    assign in_words_s[14] = fft_d14;
    assign in_words_s[15] = fft_d15;

    // The last bin of a scan is the only point inside SCAN where a new
    // frame can be accepted.
    assign last_bin_s = (state_q == SCAN) && (idx_q == 4'd15);
    assign capture_s  = fft_valid && ((state_q == IDLE) || last_bin_s);
    assign mag_s      = mag_f(buf_q[idx_q]);

    // Running max/argmax candidate for the bin currently being scanned.
    // Bin 0 always reseeds the running values. Afterwards, only a strictly
    // larger magnitude replaces them, so a tie keeps the lower index.
    always_comb begin
        cand_mag_s = max_mag_q;
        cand_idx_s = max_idx_q;
        if (idx_q == 4'd0) begin
            cand_mag_s = mag_s;
            cand_idx_s = 4'd0;
        end else if (mag_s > max_mag_q) begin
            cand_mag_s = mag_s;
            cand_idx_s = idx_q;
        end else begin
            cand_mag_s = max_mag_q;
            cand_idx_s = max_idx_q;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (idx_q != 4'd15) begin
                    state_d = SCAN;
                end else if (fft_valid) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM output logic. It computes the next values of the registered
    // outputs, so the outputs have no combinational path from the inputs.
    always_comb begin
        done_d    = 1'b0;
        freq_d    = freq_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                done_d    = 1'b0;
                freq_d    = freq_q;
                overrun_d = 1'b0;
            end
            SCAN: begin
                if (last_bin_s) begin
                    done_d    = 1'b1;
                    freq_d    = cand_idx_s;
                    overrun_d = 1'b0;
                end else begin
                    done_d    = 1'b0;
                    freq_d    = freq_q;
                    overrun_d = fft_valid;
                end
            end
            default: begin
                done_d    = 1'b0;
                freq_d    = freq_q;
                overrun_d = 1'b0;
            end
        endcase
    end

    // Datapath next-state: bin index and running max/argmax.
    always_comb begin
        idx_d     = idx_q;
        max_mag_d = max_mag_q;
        max_idx_d = max_idx_q;
        if (capture_s) begin
            idx_d = 4'd0;
        end else if (state_q == SCAN) begin
            // Wraps from 15 back to 0 when the scan returns to IDLE.
            idx_d = idx_q + 4'd1;
        end else begin
            idx_d = idx_q;
        end
        if (state_q == SCAN) begin
            max_mag_d = cand_mag_s;
            max_idx_d = cand_idx_s;
        end else begin
            max_mag_d = max_mag_q;
            max_idx_d = max_idx_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q     <= 4'd0;
            max_mag_q <= 32'd0;
            max_idx_q <= 4'd0;
            done_q    <= 1'b0;
            freq_q    <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            max_mag_q <= max_mag_d;
            max_idx_q <= max_idx_d;
            done_q    <= done_d;
            freq_q    <= freq_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame buffer. Its contents are only read while in SCAN, after a
    // capture, so it is not reset.
    always_ff @(posedge CLK) begin
        if (capture_s) begin
            for (int k = 0; k < 16; k++) begin
                buf_q[k] <= in_words_s[k];
            end
        end
    end

    assign done    = done_q;
    assign freq    = freq_q;
    assign overrun = overrun_q;

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Frame analysis stage downstream of the 16-point FFT. It captures one 16-bin FFT result on `fft_valid` and scans the bins serially, one per cycle, computing the squared magnitude of each. At the end of the scan it reports the index of the strongest bin as the dominant frequency. It sustains one frame every 16 cycles, which matches the serial-to-parallel frame rate feeding the FFT.

## Interface
- No parameters. Bin count is fixed at 16 and bin format is fixed at signed 16-bit real and imaginary parts.
- `CLK` input 1: clock. All state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `fft_valid` input 1: single-cycle pulse; `fft_d0`..`fft_d15` are valid in the same cycle.
- `fft_d0`..`fft_d15` input 32 each: bin k in natural frequency order; `[31:16]` is the signed real part, `[15:0]` is the signed imaginary part.
- `done` output 1: one-cycle pulse; `freq` is updated in the same cycle.
- `freq` output 4: index of the maximum-magnitude bin of the last completed frame; held until the next `done`.
- `overrun` output 1: one-cycle pulse when `fft_valid` arrives while the block cannot accept it.

## Operation
- States: `IDLE` and `SCAN`. Internal state:
  - 16×32 frame buffer.
  - 4-bit bin index `idx`.
  - 32-bit running maximum `max_mag`.
  - 4-bit running argmax `max_idx`.
- Capture is allowed in `IDLE`, or in `SCAN` when `idx==15`.
  - On capture, all 16 words are loaded into the buffer, `idx` is set to 0, and the next state is `SCAN`.
- `SCAN`, each cycle:
  - Compute `mag = re*re + im*im` for `buf[idx]`.
  - `re` and `im` are signed 16-bit; each product is 32 bits; the sum is treated as unsigned 32-bit. The maximum is 2^31 for (-32768, -32768), so the sum cannot overflow.
  - If `idx==0`: `max_mag` ← `mag`, `max_idx` ← 0, unconditionally.
  - Otherwise, if `mag > max_mag` (strict): `max_mag` ← `mag`, `max_idx` ← `idx`.
  - Ties keep the lower index.
- `idx==15` in `SCAN`:
  - The final compare is applied.
  - `freq` ← the resulting argmax, including bin 15 if it wins.
  - `done` ← 1.
  - If `fft_valid` is high, capture and stay in `SCAN` with `idx` ← 0.
  - Otherwise go to `IDLE`.
- `fft_valid` in `SCAN` with `idx!=15`: the frame is dropped, `overrun` ← 1 for one cycle, and the scan continues undisturbed.
- `fft_valid` is ignored entirely in reset.
- Only `[31:16]` and `[15:0]` of each word are used; there is no other interpretation of the input bits.

## Timing
- Reset values:
  - State `IDLE`, `idx`=0, `max_mag`=0, `max_idx`=0.
  - `done`=0, `freq`=0, `overrun`=0.
  - Buffer contents are don't-care.
- Latency: with `fft_valid` sampled at edge C, bins 0..15 are processed at edges C+1..C+16.
  - `done` is high during the cycle after edge C+16, i.e. 16 cycles after capture.
- Throughput: one frame per 16 cycles when `fft_valid` pulses exactly 16 cycles apart. Scans run back-to-back with no bubble.
- `done`, `freq` and `overrun` are registered outputs with no combinational path from inputs.
- `RST` asserted mid-scan: immediate return to reset values. The partial frame is discarded and no `done` is issued for it.
- `fft_valid` in two consecutive cycles while in `IDLE`: the first is captured; the second is an overrun unless `idx==15`, which cannot occur, so `overrun` pulses.

## Test plan
- Reset check: assert `RST` asynchronously between edges.
  - Required: `done`=0, `freq`=0, `overrun`=0 immediately, and no `done` for 20 cycles with `fft_valid` low.
- Single peak: bin 5 = {re=1000, im=-1000}, all others {10, 10}, one `fft_valid` pulse.
  - Required: `done` exactly 16 cycles after the capture edge, `freq`=5, `freq` holds 5 afterwards.
- Tie and extremes: bins 3 and 12 both {-32768, -32768}, all others 0.
  - Required: `freq`=3 (no overflow, lower index wins).
  - Variant with only bin 15 nonzero {1, 0}: required `freq`=15.
- Back-to-back frames: `fft_valid` every 16 cycles for 4 frames with peaks at 1, 7, 0, 14.
  - Required: four `done` pulses spaced 16 cycles apart with `freq` = 1, 7, 0, 14, and `overrun` never asserted.
- Overrun: second `fft_valid` 5 cycles after the first, with a peak at 9 in the first frame and 2 in the second.
  - Required: `overrun` pulse the cycle after the second pulse, a single `done` with `freq`=9, then `IDLE`.
- Reset mid-scan: `RST` pulse at `idx`=8.
  - Required: no `done`. A following frame with its peak at 11 yields `freq`=11 at the normal latency.
